vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
// PURPOSE
//  Shares the single-port 128x96x3-bit vram among three clients: the display
//  scanout reader, a pixel writer and an internal clear-screen engine.
//  Sits between the VGA timing/scanout logic and the vram instance.
//  Drives the vram port (ADDRA, DIA_R/G/B, WEA, ENA, SSRA) from registered outputs.
//  Framebuffer address = y*128 + x.
// PARAMETERS
//  ADDR_W    14     vram address width
//  FB_DEPTH  12288  valid pixel words (128*96); addresses >= FB_DEPTH are out of range
// PORTS
//  clk        in   1       system clock (50 MHz)
//  reset      in   1       asynchronous, active-high reset
//  rd_req     in   1       scanout read request, one cycle per pixel
//  rd_addr    in   ADDR_W  scanout read address
//  rd_valid   out  1       rd_rgb valid (1-cycle pulse)
//  rd_rgb     out  3       {R,G,B} read data
//  wr_req     in   1       writer request; addr/data held until wr_ack
//  wr_addr    in   ADDR_W  writer address
//  wr_rgb     in   3       writer {R,G,B}
//  wr_ack     out  1       1-cycle pulse: write accepted
//  wr_err     out  1       1-cycle pulse with wr_ack when wr_addr >= FB_DEPTH
//  clr_start  in   1       start clear-screen
//  clr_rgb    in   3       fill colour, sampled on accepted clr_start
//  clr_busy   out  1       clear in progress
//  clr_done   out  1       1-cycle pulse after last clear write issued
//  ADDRA      out  ADDR_W  to vram
//  DIA_R/G/B  out  1 each  to vram
//  WEA, ENA   out  1       to vram
//  SSRA       out  1       to vram
//  DOA_R/G/B  in   1 each  from vram
// BEHAVIOUR
//  - Reset: all outputs 0 (ADDRA=0, WEA=0, ENA=0, SSRA=0, rd_valid=0, wr_ack=0,
//    wr_err=0, clr_busy=0, clr_done=0, rd_rgb=0); FSM -> IDLE; clear counter -> 0.
//  - Reset mid-clear aborts the clear; no clr_done is issued.
//  - One vram access per cycle. Priority: scanout read > clear > writer.
//  - Read: rd_req sampled at edge N -> ADDRA=rd_addr, ENA=1, WEA=0 after edge N.
//    vram samples at edge N+1; rd_rgb registered from DOA at edge N+2; rd_valid
//    pulses for the cycle after N+2.
//  - Fixed read latency: 2 cycles. Back-to-back reads are allowed and are
//    always served.
//  - Write slot: granted only in cycles with no rd_req. ADDRA/DIA/WEA=1/ENA=1
//    registered at the grant edge; wr_ack pulses the same cycle the port drives.
//  - Out-of-range wr_addr: wr_ack=1, wr_err=1, WEA=0 (write suppressed).
//  - Idle cycle: ENA=0, WEA=0, ADDRA holds its last value. SSRA is always 0.
//  - FSM IDLE: clr_start=1 -> CLEAR; latch clr_rgb; counter=0; clr_busy=1.
//  - FSM CLEAR: each cycle without rd_req writes clr_rgb at counter, counter+1.
//    After the write at FB_DEPTH-1: -> IDLE, clr_done pulse, clr_busy=0.
//  - clr_start while in CLEAR is ignored.
//  - In CLEAR, wr_req is stalled (no wr_ack) until CLEAR exits.
//  - Simultaneous clr_start and wr_req in IDLE: clear wins; the write waits.
//  - Counter is ADDR_W bits wide. It never wraps, because the terminal compare
//    happens at FB_DEPTH-1.
//  - The writer can starve while rd_req is continuous. Scanout at the 25 MHz
//    pixel rate requests at most every other cycle.
// STRUCTURE
//  - Shared include vga_defs.vh: FB_W=128, FB_H=96, FB_DEPTH, ADDR_W, RGB width 3,
//    FSM state encodings.
//  - One sub-module: vram_clear_seq (counter, clr_rgb latch, busy/done, and
//    a "slot free" input). The arbiter mux and output registers stay in the top.
// TESTING
//  - Reset, then rd_req at addr 1 with vram init RED at 1 ->
//    rd_valid 2 cycles later, rd_rgb=3'b100.
//  - wr_req addr 9217 rgb 3'b010 with rd_req idle -> wr_ack next cycle, WEA=1,
//    ADDRA=9217. A following read of 9217 returns 3'b010.
//  - rd_req every cycle for 10 cycles with wr_req pending -> no wr_ack and 10
//    rd_valid pulses. rd_req drops -> wr_ack within 1 cycle.
//  - clr_start rgb 3'b001, rd_req alternating -> exactly 12288 WEA pulses at
//    addresses 0..12287. clr_done once; wr_req during clear is acked only after.
//  - wr_addr=12288 -> wr_ack=1, wr_err=1, WEA=0.
//  - Reset asserted mid-clear at count 500 -> outputs 0 at once, clr_busy=0,
//    no clr_done. A new clr_start restarts at address 0.

Source files
------------

// File: rtl/vram_arbiter_pkg.sv
// Shared framebuffer geometry, clear-FSM state encodings and arbiter grant type
// for the vram arbiter slice.
package vram_arbiter_pkg;

    localparam int FB_W        = 128;
    localparam int FB_H        = 96;
    localparam int VRAM_DEPTH  = FB_W * FB_H;
    localparam int VRAM_ADDR_W = 14;
    localparam int RGB_W       = 3;

    typedef logic [RGB_W-1:0] rgb_t;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_READ,
        GNT_CLEAR,
        GNT_WRITE
    } gnt_e;

    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/vram_arbiter_clear_seq.sv
// Clear-screen sequencer: walks the whole framebuffer once per start, issuing a
// write in every cycle the arbiter reports the vram slot as free.
module vram_clear_seq
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_W   = VRAM_ADDR_W,
    parameter int FB_DEPTH = VRAM_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  rgb_t              rgb_i,
    input  logic              slot_free_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              wr_o,
    output logic [ADDR_W-1:0] addr_o,
    output rgb_t              rgb_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    rgb_t              rgb_q, rgb_d;
    logic              done_q, done_d;
    logic              wr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rgb_d   = rgb_q;
        done_d  = 1'b0;
        wr      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    rgb_d   = rgb_i;
                end
            end
            ST_CLEAR: begin
                if (slot_free_i) begin
                    wr = 1'b1;
                    // Terminal compare on the last valid word keeps the counter from wrapping.
                    if (cnt_q == LAST_ADDR) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rgb_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rgb_q   <= rgb_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (state_q == ST_CLEAR);
    assign done_o = done_q;
    assign wr_o   = wr;
    assign addr_o = cnt_q;
    assign rgb_o  = rgb_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port vram arbiter: scanout reads beat the clear engine, which beats the
// pixel writer. Every vram port signal comes straight from a register.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_W   = VRAM_ADDR_W,
    parameter int FB_DEPTH = VRAM_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [2:0]        rd_rgb,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [2:0]        wr_rgb,
    output logic              wr_ack,
    output logic              wr_err,
    input  logic              clr_start,
    input  logic [2:0]        clr_rgb,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] ADDRA,
    output logic              DIA_R,
    output logic              DIA_G,
    output logic              DIA_B,
    output logic              WEA,
    output logic              ENA,
    output logic              SSRA,
    input  logic              DOA_R,
    input  logic              DOA_G,
    input  logic              DOA_B
);

    logic              clr_wr;
    logic [ADDR_W-1:0] clr_addr;
    rgb_t              clr_fill;
    logic              wr_in_range;
    gnt_e              gnt;

    logic [ADDR_W-1:0] addra_q, addra_d;
    rgb_t              dia_q, dia_d;
    logic              wea_q, wea_d;
    logic              ena_q, ena_d;
    logic              wr_ack_q, wr_ack_d;
    logic              wr_err_q, wr_err_d;
    logic              rd_vld_p0_q, rd_vld_p1_q, rd_vld_p2_q;
    rgb_t              rd_rgb_q;

    vram_clear_seq #(
        .ADDR_W   (ADDR_W),
        .FB_DEPTH (FB_DEPTH)
    ) u_clear_seq (
        .clk         (clk),
        .reset       (reset),
        .start_i     (clr_start),
        .rgb_i       (clr_rgb),
        .slot_free_i (!rd_req),
        .busy_o      (clr_busy),
        .done_o      (clr_done),
        .wr_o        (clr_wr),
        .addr_o      (clr_addr),
        .rgb_o       (clr_fill)
    );

    assign wr_in_range = addr_in_range(32'(wr_addr), FB_DEPTH);

    // The writer also yields to a clr_start arriving in IDLE, and skips the cycle
    // right after its own ack so a held request is not accepted twice.
    always_comb begin
        gnt = GNT_NONE;
        if (rd_req) begin
            gnt = GNT_READ;
        end else if (clr_wr) begin
            gnt = GNT_CLEAR;
        end else if (wr_req && !clr_busy && !clr_start && !wr_ack_q) begin
            gnt = GNT_WRITE;
        end
    end

    always_comb begin
        addra_d  = addra_q;
        dia_d    = dia_q;
        wea_d    = 1'b0;
        ena_d    = 1'b0;
        wr_ack_d = 1'b0;
        wr_err_d = 1'b0;
        case (gnt)
            GNT_READ: begin
                addra_d = rd_addr;
                ena_d   = 1'b1;
            end
            GNT_CLEAR: begin
                addra_d = clr_addr;
                dia_d   = clr_fill;
                wea_d   = 1'b1;
                ena_d   = 1'b1;
            end
            GNT_WRITE: begin
                wr_ack_d = 1'b1;
                wr_err_d = !wr_in_range;
                if (wr_in_range) begin
                    addra_d = wr_addr;
                    dia_d   = wr_rgb;
                    wea_d   = 1'b1;
                    ena_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addra_q     <= '0;
            dia_q       <= '0;
            wea_q       <= 1'b0;
            ena_q       <= 1'b0;
            wr_ack_q    <= 1'b0;
            wr_err_q    <= 1'b0;
            rd_vld_p0_q <= 1'b0;
            rd_vld_p1_q <= 1'b0;
            rd_vld_p2_q <= 1'b0;
            rd_rgb_q    <= '0;
        end else begin
            // p0: port driven
            addra_q     <= addra_d;
            dia_q       <= dia_d;
            wea_q       <= wea_d;
            ena_q       <= ena_d;
            wr_ack_q    <= wr_ack_d;
            wr_err_q    <= wr_err_d;
            rd_vld_p0_q <= (gnt == GNT_READ);
            // p1: vram has sampled the address
            rd_vld_p1_q <= rd_vld_p0_q;
            // p2: read data captured from DOA
            rd_vld_p2_q <= rd_vld_p1_q;
            if (rd_vld_p1_q) begin
                rd_rgb_q <= {DOA_R, DOA_G, DOA_B};
            end
        end
    end

    assign ADDRA    = addra_q;
    assign DIA_R    = dia_q[2];
    assign DIA_G    = dia_q[1];
    assign DIA_B    = dia_q[0];
    assign WEA      = wea_q;
    assign ENA      = ena_q;
    assign SSRA     = 1'b0;
    assign wr_ack   = wr_ack_q;
    assign wr_err   = wr_err_q;
    assign rd_valid = rd_vld_p2_q;
    assign rd_rgb   = rd_rgb_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural read-first single-port vram.
module tb_vram_arbiter;

    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              reset;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [2:0]        rd_rgb;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [2:0]        wr_rgb;
    logic              wr_ack;
    logic              wr_err;
    logic              clr_start;
    logic [2:0]        clr_rgb;
    logic              clr_busy;
    logic              clr_done;
    logic [ADDR_W-1:0] ADDRA;
    logic              DIA_R, DIA_G, DIA_B;
    logic              WEA, ENA, SSRA;
    logic [2:0]        doa;

    int n_vec  = 0;
    int n_miss = 0;

    always #10 clk = ~clk;

    vram_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_rgb    (rd_rgb),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_rgb    (wr_rgb),
        .wr_ack    (wr_ack),
        .wr_err    (wr_err),
        .clr_start (clr_start),
        .clr_rgb   (clr_rgb),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .ADDRA     (ADDRA),
        .DIA_R     (DIA_R),
        .DIA_G     (DIA_G),
        .DIA_B     (DIA_B),
        .WEA       (WEA),
        .ENA       (ENA),
        .SSRA      (SSRA),
        .DOA_R     (doa[2]),
        .DOA_G     (doa[1]),
        .DOA_B     (doa[0])
    );

    // Read-first vram model; reloads its initial image while reset is high.
    logic [2:0] mem [0:16383];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16384; i++) mem[i] <= 3'b000;
            mem[1] <= 3'b100;
            doa    <= 3'b000;
        end else if (ENA) begin
            if (WEA) mem[ADDRA] <= {DIA_R, DIA_G, DIA_B};
            doa <= mem[ADDRA];
        end
    end

    task automatic check_vec(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int valids, acks, nclr, bad, dones, early, got_ack, nwr;
        logic rd_t;

        reset = 1'b1; rd_req = 0; rd_addr = '0; wr_req = 0; wr_addr = '0;
        wr_rgb = '0; clr_start = 0; clr_rgb = '0;
        repeat (3) tick();
        check_vec("rst_addra", ADDRA, 0);
        check_vec("rst_wea", WEA, 0);
        check_vec("rst_ena", ENA, 0);
        check_vec("rst_ssra", SSRA, 0);
        check_vec("rst_rd_valid", rd_valid, 0);
        check_vec("rst_rd_rgb", rd_rgb, 0);
        check_vec("rst_wr_ack", wr_ack, 0);
        check_vec("rst_wr_err", wr_err, 0);
        check_vec("rst_clr_busy", clr_busy, 0);
        check_vec("rst_clr_done", clr_done, 0);
        reset = 1'b0;
        tick();

        // Single read of the preloaded red pixel at address 1
        rd_req = 1; rd_addr = 14'd1;
        tick();
        check_vec("rd_addra", ADDRA, 1);
        check_vec("rd_ena", ENA, 1);
        check_vec("rd_wea", WEA, 0);
        rd_req = 0;
        tick();
        check_vec("rd_valid_early", rd_valid, 0);
        tick();
        check_vec("rd_valid", rd_valid, 1);
        check_vec("rd_rgb_red", rd_rgb, 3'b100);
        tick();
        check_vec("rd_valid_pulse", rd_valid, 0);

        // Writer access with the read port idle, then read it back
        wr_req = 1; wr_addr = 14'd9217; wr_rgb = 3'b010;
        tick();
        check_vec("wr_ack", wr_ack, 1);
        check_vec("wr_wea", WEA, 1);
        check_vec("wr_ena", ENA, 1);
        check_vec("wr_addra", ADDRA, 9217);
        check_vec("wr_dia", {DIA_R, DIA_G, DIA_B}, 3'b010);
        check_vec("wr_err_inrange", wr_err, 0);
        wr_req = 0;
        tick();
        check_vec("wr_ack_pulse", wr_ack, 0);
        check_vec("wr_wea_drop", WEA, 0);
        rd_req = 1; rd_addr = 14'd9217;
        tick();
        rd_req = 0;
        tick();
        tick();
        check_vec("rdback_valid", rd_valid, 1);
        check_vec("rdback_rgb", rd_rgb, 3'b010);

        // Ten back-to-back reads starve a pending write
        valids = 0; acks = 0;
        wr_req = 1; wr_addr = 14'd100; wr_rgb = 3'b111;
        for (int i = 0; i < 10; i++) begin
            rd_req = 1; rd_addr = ADDR_W'(i);
            tick();
            valids += int'(rd_valid);
            acks   += int'(wr_ack);
        end
        rd_req = 0;
        tick();
        check_vec("wr_after_reads", wr_ack, 1);
        valids += int'(rd_valid);
        wr_req = 0;
        tick();
        valids += int'(rd_valid);
        check_vec("starved_acks", acks, 0);
        check_vec("b2b_valids", valids, 10);

        // Clear with a simultaneous write request and alternating scanout reads
        clr_start = 1; clr_rgb = 3'b001;
        wr_req = 1; wr_addr = 14'd50; wr_rgb = 3'b011;
        tick();
        check_vec("clr_busy_start", clr_busy, 1);
        check_vec("clr_wins", wr_ack, 0);
        clr_start = 0;
        nclr = 0; bad = 0; dones = 0; early = 0; got_ack = 0; rd_t = 1'b1;
        for (int c = 0; c < 40000 && got_ack == 0; c++) begin
            rd_req = rd_t; rd_addr = 14'd7; rd_t = ~rd_t;
            tick();
            if (clr_done) begin
                dones++;
                if (clr_busy) bad++;
            end
            if (wr_ack) begin
                if (dones == 0) early++;
                got_ack = 1;
                wr_req = 0;
            end else if (WEA) begin
                if (ADDRA != ADDR_W'(nclr) || {DIA_R, DIA_G, DIA_B} != 3'b001) bad++;
                nclr++;
            end
        end
        rd_req = 0;
        check_vec("clr_wea_cnt", nclr, 12288);
        check_vec("clr_addr_bad", bad, 0);
        check_vec("clr_done_cnt", dones, 1);
        check_vec("wr_ack_early", early, 0);
        check_vec("wr_ack_after_clr", got_ack, 1);
        check_vec("clr_busy_end", clr_busy, 0);
        tick();

        // Out-of-range writer address is acked but suppressed; last valid word is not
        wr_req = 1; wr_addr = 14'd12288; wr_rgb = 3'b111;
        tick();
        check_vec("oor_ack", wr_ack, 1);
        check_vec("oor_err", wr_err, 1);
        check_vec("oor_wea", WEA, 0);
        wr_req = 0;
        tick();
        check_vec("oor_err_pulse", wr_err, 0);
        wr_req = 1; wr_addr = 14'd12287;
        tick();
        check_vec("edge_err", wr_err, 0);
        check_vec("edge_wea", WEA, 1);
        wr_req = 0;
        tick();

        // Reset in the middle of a clear, then restart
        clr_start = 1; clr_rgb = 3'b110;
        tick();
        clr_start = 0;
        nwr = 0;
        for (int c = 0; c < 1000 && nwr < 500; c++) begin
            tick();
            if (WEA) nwr++;
        end
        check_vec("pre_rst_writes", nwr, 500);
        reset = 1'b1;
        #1;
        check_vec("mid_rst_wea", WEA, 0);
        check_vec("mid_rst_ena", ENA, 0);
        check_vec("mid_rst_addra", ADDRA, 0);
        check_vec("mid_rst_busy", clr_busy, 0);
        tick();
        reset = 1'b0;
        dones = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            dones += int'(clr_done);
        end
        check_vec("aborted_no_done", dones, 0);
        clr_start = 1; clr_rgb = 3'b101;
        tick();
        clr_start = 0;
        tick();
        check_vec("restart_wea", WEA, 1);
        check_vec("restart_addr0", ADDRA, 0);
        tick();
        check_vec("restart_addr1", ADDRA, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
